// File: rtl/lab1_pkg.sv
// Shared definitions for the lab sequential library.
// Holds the width limit and the boundary-mode encoding used by the counters.
package lab1_pkg;

  localparam int WIDTH_MAX = 16;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } bound_mode_e;

endpackage

// File: rtl/toggle_cell.sv
// One bit of toggle storage: synchronous clear, parallel load, toggle on t.
// Load wins over t so a parallel load never races a count step.
module toggle_cell (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_bit,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (load) begin
      q <= load_bit;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/toggle_counter.sv
// Up/down counter built from a chain of toggle cells, with wrap or saturate
// behaviour at the bound and a registered terminal-count flag.
module toggle_counter
  import lab1_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  // ones_chain[i] / zeros_chain[i]: bits below i are all ones / all zeros.
  // The top entry doubles as the bound detect for each direction.
  logic [WIDTH:0]   ones_chain;
  logic [WIDTH:0]   zeros_chain;
  logic [WIDTH-1:0] t;
  logic             at_bound;
  logic             hold;
  logic             step;
  bound_mode_e      mode;

  assign ones_chain[0]  = 1'b1;
  assign zeros_chain[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    assign ones_chain[i+1]  = ones_chain[i]  &  q[i];
    assign zeros_chain[i+1] = zeros_chain[i] & ~q[i];
  end

  assign mode     = sat ? SAT : WRAP;
  assign at_bound = up ? ones_chain[WIDTH] : zeros_chain[WIDTH];
  assign hold     = (mode == SAT) && at_bound;
  assign step     = en && !hold;

  // Saturation gates every toggle at once, so the value freezes at the bound.
  always_comb begin
    t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = step & (up ? ones_chain[i] : zeros_chain[i]);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    toggle_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_bit (load_val[i]),
      .t        (t[i]),
      .q        (q[i])
    );
  end

  // tc reflects the bound seen on this enabled edge; loads never raise it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc <= 1'b0;
    end else if (load) begin
      tc <= 1'b0;
    end else begin
      tc <= en & at_bound;
    end
  end

endmodule

// File: tb/tb_toggle_counter.sv
// Scoreboard bench for toggle_counter at widths 4, 1 and 16 sharing one
// control stream; a reference model predicts each edge's result.
module tb_toggle_counter;

  typedef struct {
    int          due;
    logic [15:0] q;
    logic        tc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        sat = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  lv4 = '0;
  logic [0:0]  lv1 = '0;
  logic [15:0] lv16 = '0;

  logic [3:0]  dq4;
  logic [0:0]  dq1;
  logic [15:0] dq16;
  logic        dtc4, dtc1, dtc16;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  exp_t sb4[$];
  exp_t sb1[$];
  exp_t sb16[$];

  exp_t m4 = '{0, 16'h0, 1'b0};
  exp_t m1 = '{0, 16'h0, 1'b0};
  exp_t m16 = '{0, 16'h0, 1'b0};

  toggle_counter #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
    .load(load), .load_val(lv4), .q(dq4), .tc(dtc4)
  );

  toggle_counter #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
    .load(load), .load_val(lv1), .q(dq1), .tc(dtc1)
  );

  toggle_counter #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
    .load(load), .load_val(lv16), .q(dq16), .tc(dtc16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural model: next value computed from count arithmetic and bounds.
  function automatic exp_t modelStep(int w, exp_t cur, logic r, logic l,
                                     logic e, logic u, logic s,
                                     logic [15:0] lv);
    int unsigned maxv;
    int unsigned v;
    bit bound;
    exp_t n;
    maxv = (32'd1 << w) - 1;
    v = 32'(cur.q);
    n.due = 0;
    n.q = cur.q;
    n.tc = 1'b0;
    if (r) begin
      n.q = 16'h0;
    end else if (l) begin
      n.q = 16'(32'(lv) & maxv);
    end else if (e) begin
      bound = u ? (v == maxv) : (v == 0);
      if (bound) begin
        n.tc = 1'b1;
        if (!s) n.q = u ? 16'h0 : 16'(maxv);
      end else begin
        n.q = u ? 16'(v + 1) : 16'(v - 1);
      end
    end
    return n;
  endfunction

  task automatic applyStimulus(input logic r, input logic l, input logic e,
                               input logic u, input logic s,
                               input logic [15:0] v4, input logic [15:0] v1,
                               input logic [15:0] v16);
    @(posedge clk);
    #1;
    rst = r; load = l; en = e; up = u; sat = s;
    lv4 = v4[3:0]; lv1 = v1[0:0]; lv16 = v16;
    m4 = modelStep(4, m4, r, l, e, u, s, v4);
    m1 = modelStep(1, m1, r, l, e, u, s, v1);
    m16 = modelStep(16, m16, r, l, e, u, s, v16);
    m4.due = cyc + 1;
    m1.due = cyc + 1;
    m16.due = cyc + 1;
    sb4.push_back(m4);
    sb1.push_back(m1);
    sb16.push_back(m16);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] aq,
                             input logic atc, input exp_t e);
    vectors++;
    if (aq !== e.q) begin
      miscompares++;
      $display("[TB] FAIL %s_q cycle %0d: got %h expected %h", name, e.due, aq, e.q);
    end
    vectors++;
    if (atc !== e.tc) begin
      miscompares++;
      $display("[TB] FAIL %s_tc cycle %0d: got %b expected %b", name, e.due, atc, e.tc);
    end
  endtask

  // Monitor: outputs are registered, so each edge presents one result.
  always @(negedge clk) begin
    while (sb4.size() > 0 && sb4[0].due == cyc) checkOutput("w4", 16'(dq4), dtc4, sb4.pop_front());
    while (sb1.size() > 0 && sb1[0].due == cyc) checkOutput("w1", 16'(dq1), dtc1, sb1.pop_front());
    while (sb16.size() > 0 && sb16[0].due == cyc) checkOutput("w16", dq16, dtc16, sb16.pop_front());
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic r, l, e, u, s;
    logic [15:0] v16;

    // Reset, then a full up-count with wrap.
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);

    // Down-count wrap from 2.
    applyStimulus(0, 1, 0, 1, 0, 16'h2, 0, 16'h2);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);

    // Saturation at the top, then turn around.
    applyStimulus(0, 1, 0, 1, 1, 16'hE, 0, 16'hFFFE);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 1, 0, 0, 0);

    // Load beats enable, then hold.
    applyStimulus(0, 1, 0, 1, 0, 16'h5, 1, 16'h5);
    applyStimulus(0, 1, 1, 1, 0, 16'h9, 0, 16'h9);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);

    // Reset beats load mid-count.
    applyStimulus(0, 1, 0, 1, 0, 16'hB, 1, 16'hB);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 0, 16'h3, 1, 16'h3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);

    // Wide wrap from all ones.
    applyStimulus(0, 1, 0, 1, 0, 16'hF, 1, 16'hFFFF);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 0, 0, 0);

    // Random traffic with sticky direction/mode so bounds get exercised.
    u = 1; s = 0;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 7) == 0) u = ~u;
      if ($urandom_range(0, 15) == 0) s = ~s;
      case ($urandom_range(0, 4))
        0: v16 = 16'hFFFF;
        1: v16 = 16'h0000;
        2: v16 = 16'hFFFE;
        3: v16 = 16'h0001;
        default: v16 = 16'($urandom);
      endcase
      applyStimulus(r, l, e, u, s, 16'($urandom), 16'($urandom), v16);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb4.size() != 0 || sb1.size() != 0 || sb16.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d/%0d/%0d pending expected 0",
               sb4.size(), sb1.size(), sb16.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
